// File: rtl/imem_pipelined.sv
// imem_pipelined: synchronous-read instruction memory with a LATENCY-deep
// valid/ready response pipeline, flush, stall and a word-wide load port.
// Optional build macro: IMEM_PARITY_EN (stores and checks an even parity bit per word).
module imem_pipelined #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH_WORDS = 1024,
    parameter int               LATENCY     = 1,
    parameter string            INIT_FILE   = "",
    parameter logic [WIDTH-1:0] NOP         = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [WIDTH-1:0]               req_addr_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [WIDTH-1:0]               rsp_data_o,
    output logic                           rsp_fault_o,
    input  logic                           flush_i,
    input  logic                           load_en_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [WIDTH-1:0]               load_data_i,
    input  logic                           load_par_inv_i,
    output logic                           parity_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
`ifdef IMEM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [MW-1:0]      mem      [DEPTH_WORDS];

    logic [AW-1:0]      req_idx;
    logic               req_fault;
    logic [MW-1:0]      rd_word;
    logic [WIDTH-1:0]   rd_data;
    logic               rd_perr;
    logic               stall;
    logic               accept;

    // One entry per pipeline stage; the last stage drives the response port.
    logic [LATENCY-1:0] st_v;
    logic [LATENCY-1:0] st_f;
    logic [LATENCY-1:0] st_p;
    logic [WIDTH-1:0]   st_d [LATENCY];

    // Stored word layout: {parity, data} with parity, plain data without.
    function automatic logic [MW-1:0] encode(input logic [WIDTH-1:0] d, input logic inv);
`ifdef IMEM_PARITY_EN
        return {(^d) ^ inv, d};
`else
        logic unused_inv;
        unused_inv = inv;
        return d;
`endif
    endfunction

    // Boot image: every word is NOP.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = encode(NOP, 1'b0);
    end

    // Load port write, independent of fetch traffic and stalls.
    // NOTE: the array has no reset branch; contents survive rst_n, which only masks loads.
    always_ff @(posedge clk) begin
        if (rst_n && load_en_i) mem[load_addr_i] <= encode(load_data_i, load_par_inv_i);
    end

    // Address decode and array read; upper address bits never wrap into the array.
    always_comb begin
        req_idx   = req_addr_i[AW+1:2];
        req_fault = (req_addr_i[1:0] != 2'b00) || (req_addr_i[WIDTH-1:AW+2] != '0);
        rd_word   = mem[req_idx];
        rd_data   = rd_word[WIDTH-1:0];
`ifdef IMEM_PARITY_EN
        rd_perr   = ^rd_word;
`else
        rd_perr   = 1'b0;
`endif
    end

    assign stall       = st_v[LATENCY-1] && !rsp_ready_i;
    assign req_ready_o = !stall && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    // Pipeline advance: flush beats stall, stall freezes everything, data moves only with valid entries.
    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v <= '0;
            st_f <= '0;
            st_p <= '0;
            for (int k = 0; k < LATENCY; k++) st_d[k] <= '0;
        end else if (flush_i) begin
            st_v <= '0;
        end else if (!stall) begin
            st_v[0] <= accept;
            if (accept) begin
                st_d[0] <= req_fault ? NOP : rd_data;
                st_f[0] <= req_fault || rd_perr;
                st_p[0] <= !req_fault && rd_perr;
            end
            for (int k = 1; k < LATENCY; k++) begin
                st_v[k] <= st_v[k-1];
                if (st_v[k-1]) begin
                    st_d[k] <= st_d[k-1];
                    st_f[k] <= st_f[k-1];
                    st_p[k] <= st_p[k-1];
                end
            end
        end
    end

    assign rsp_valid_o  = st_v[LATENCY-1];
    assign rsp_data_o   = st_d[LATENCY-1];
    assign rsp_fault_o  = st_f[LATENCY-1];
    assign parity_err_o = st_p[LATENCY-1];
endmodule
